// File: rtl/pe_mux_arbiter_if.sv
// Requester / writeback handshake bundle for pe_mux_arbiter.
// master = arbiter side, slave = requesters plus downstream consumer.
interface pe_mux_arbiter_if #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned SEL_WIDTH = 3
);
    localparam int unsigned N = 1 << SEL_WIDTH;

    logic [N-1:0]         req_valid;
    logic [N-1:0]         req_last;
    logic [WIDTH-1:0]     req_data [N-1:0];
    logic [N-1:0]         req_ready;
    logic [SEL_WIDTH-1:0] mux_sel;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [SEL_WIDTH-1:0] out_src;
    logic                 out_last;
    logic                 out_ready;
    logic                 busy;
    logic                 timeout_err;

    modport master (
        input  req_valid, req_last, req_data, out_ready,
        output req_ready, mux_sel, out_valid, out_data, out_src, out_last, busy, timeout_err
    );

    modport slave (
        output req_valid, req_last, req_data, out_ready,
        input  req_ready, mux_sel, out_valid, out_data, out_src, out_last, busy, timeout_err
    );
endinterface

// File: rtl/pe_mux_arbiter.sv
// Round-robin burst arbiter driving the PE result mux select, with one registered output stage.
// Optional idle-grant timeout enabled by defining PE_MUX_ARB_TIMEOUT_EN.
module pe_mux_arbiter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned SEL_WIDTH = 3,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    pe_mux_arbiter_if.master bus
);
    localparam int unsigned N = 1 << SEL_WIDTH;

    if (TIMEOUT < 1) begin : g_timeout_chk
        $error("TIMEOUT must be at least 1");
    end

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e               state;
    logic [SEL_WIDTH-1:0] rr_ptr;
    logic [SEL_WIDTH-1:0] mux_sel;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [SEL_WIDTH-1:0] out_src;
    logic                 out_last;
    logic                 timeout_err;

    logic [SEL_WIDTH-1:0] winner;
    logic [SEL_WIDTH-1:0] cand;
    logic                 found;
    logic                 can_load;
    logic                 accept;
    logic                 tmo_hit;

    // First valid requester at or above rr_ptr, wrapping modulo N.
    always_comb begin
        winner = rr_ptr;
        cand   = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = SEL_WIDTH'(rr_ptr + i);
            if (!found && bus.req_valid[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign can_load = !out_valid || bus.out_ready;
    assign accept   = (state == StBusy) && can_load && bus.req_valid[mux_sel];

    always_comb begin
        bus.req_ready = '0;
        if (state == StBusy) begin
            bus.req_ready[mux_sel] = can_load;
        end
    end

`ifdef PE_MUX_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] idle_cnt;
    logic [CntW-1:0] idle_cnt_inc;

    assign idle_cnt_inc = idle_cnt + 1'b1;
    // Release on the edge that would bring the idle count to TIMEOUT.
    assign tmo_hit = (state == StBusy) && !bus.req_valid[mux_sel] &&
                     (idle_cnt_inc == CntW'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if ((state != StBusy) || bus.req_valid[mux_sel] || tmo_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt_inc;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            rr_ptr      <= '0;
            mux_sel     <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_src     <= '0;
            out_last    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= tmo_hit;
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= bus.req_data[mux_sel];
                out_src   <= mux_sel;
                out_last  <= bus.req_last[mux_sel];
            end else if (bus.out_ready) begin
                out_valid <= 1'b0;
            end
            unique case (state)
                StIdle: begin
                    if (|bus.req_valid) begin
                        mux_sel <= winner;
                        state   <= StBusy;
                    end
                end
                StBusy: begin
                    if ((accept && bus.req_last[mux_sel]) || tmo_hit) begin
                        state  <= StIdle;
                        rr_ptr <= mux_sel + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.mux_sel     = mux_sel;
    assign bus.out_valid   = out_valid;
    assign bus.out_data    = out_data;
    assign bus.out_src     = out_src;
    assign bus.out_last    = out_last;
    assign bus.busy        = (state == StBusy);
    assign bus.timeout_err = timeout_err;

endmodule

// File: tb/tb_pe_mux_arbiter.sv
// Self-checking bench for pe_mux_arbiter: cycle model of the arbitration rules plus
// directed scenarios with hand-computed expectations.
module tb_pe_mux_arbiter;
    localparam int unsigned WIDTH     = 8;
    localparam int unsigned SEL_WIDTH = 3;
    localparam int unsigned TIMEOUT   = 8;
    localparam int unsigned N         = 1 << SEL_WIDTH;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pe_mux_arbiter_if #(.WIDTH(WIDTH), .SEL_WIDTH(SEL_WIDTH)) bus ();

    pe_mux_arbiter #(
        .WIDTH    (WIDTH),
        .SEL_WIDTH(SEL_WIDTH),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Burst sources: cnt beats left in the current burst, reloads further bursts of blen.
    int         cnt     [N];
    int         reloads [N];
    int         blen    [N];
    int         acc_cnt [N];
    logic [7:0] nxt     [N];
    bit         hold    [N];

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i] = (cnt[i] > 0) && !hold[i];
            bus.req_last[i]  = (cnt[i] == 1);
            bus.req_data[i]  = nxt[i];
        end
    endtask

    function automatic bit sources_empty();
        bit e = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (cnt[i] != 0 || reloads[i] != 0) e = 1'b0;
        end
        return e;
    endfunction

    task automatic step();
        logic [N-1:0] hs;
        @(negedge clk);
        hs = bus.req_ready & bus.req_valid;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                cnt[i]--;
                nxt[i]++;
                acc_cnt[i]++;
                if (cnt[i] == 0 && reloads[i] > 0) begin
                    reloads[i]--;
                    cnt[i] = blen[i];
                end
            end
        end
        apply();
    endtask

    // Reference model: grant owner, round-robin pointer, output register contents.
    bit         m_busy = 1'b0;
    int         m_sel  = 0;
    int         m_rr   = 0;
    bit         m_ov   = 1'b0;
    logic [7:0] m_od   = '0;
    int         m_os   = 0;
    bit         m_ol   = 1'b0;
    bit         m_terr = 1'b0;
    int         m_idle = 0;

    initial forever begin : model
        bit can;
        bit acc;
        bit found;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_busy = 0; m_sel = 0; m_rr = 0; m_ov = 0; m_od = '0;
            m_os = 0; m_ol = 0; m_terr = 0; m_idle = 0;
        end else begin
            can    = !m_ov || bus.out_ready;
            acc    = m_busy && can && bus.req_valid[m_sel];
            m_terr = 0;
            if (m_ov && bus.out_ready) m_ov = 0;
            if (acc) begin
                m_ov = 1;
                m_od = bus.req_data[m_sel];
                m_os = m_sel;
                m_ol = bus.req_last[m_sel];
            end
            if (!m_busy) begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    if (!found && bus.req_valid[(m_rr + k) % N]) begin
                        m_sel  = (m_rr + k) % N;
                        m_busy = 1;
                        found  = 1;
                    end
                end
                m_idle = 0;
            end else if (acc && bus.req_last[m_sel]) begin
                m_busy = 0;
                m_rr   = (m_sel + 1) % N;
            end
`ifdef PE_MUX_ARB_TIMEOUT_EN
            else begin
                m_idle = bus.req_valid[m_sel] ? 0 : m_idle + 1;
                if (m_idle == TIMEOUT) begin
                    m_busy = 0;
                    m_rr   = (m_sel + 1) % N;
                    m_terr = 1;
                    m_idle = 0;
                end
            end
`endif
        end
    end

    int         log_src  [$];
    logic [7:0] log_data [$];
    bit         log_last [$];
    int         busy_cycles = 0;
    int         terr_pulses = 0;

    initial forever begin : compare
        logic [N-1:0] exp_ready;
        @(negedge clk);
        if (rst_n) begin
            exp_ready = '0;
            if (m_busy && (!m_ov || bus.out_ready)) exp_ready[m_sel] = 1'b1;
            check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
            check("req_ready_onehot0", 32'($onehot0(bus.req_ready)), 32'd1);
            check("mux_sel", 32'(bus.mux_sel), 32'(m_sel));
            check("busy", 32'(bus.busy), 32'(m_busy));
            check("out_valid", 32'(bus.out_valid), 32'(m_ov));
            check("timeout_err", 32'(bus.timeout_err), 32'(m_terr));
            if (m_ov) begin
                check("out_data", 32'(bus.out_data), 32'(m_od));
                check("out_src", 32'(bus.out_src), 32'(m_os));
                check("out_last", 32'(bus.out_last), 32'(m_ol));
            end
            if (bus.out_valid && bus.out_ready) begin
                log_src.push_back(int'(bus.out_src));
                log_data.push_back(bus.out_data);
                log_last.push_back(bus.out_last);
            end
            if (bus.busy) busy_cycles++;
            if (bus.timeout_err) terr_pulses++;
        end
    end

    task automatic clear_sources();
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0; reloads[i] = 0; blen[i] = 0; acc_cnt[i] = 0;
            nxt[i] = 8'(i * 16); hold[i] = 0;
        end
        apply();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_sources();
        bus.out_ready = 1'b1;
        log_src.delete(); log_data.delete(); log_last.delete();
        busy_cycles = 0;
        terr_pulses = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain(input string name);
        bit done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            step();
            done = sources_empty() && !bus.busy && !bus.out_valid;
        end
        check(name, 32'(done), 32'd1);
    endtask

    task automatic wait_acc(input string name, input int idx, input int n);
        for (int c = 0; c < 50 && acc_cnt[idx] < n; c++) step();
        check(name, 32'(acc_cnt[idx] >= n), 32'd1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_out_data"}, 32'(bus.out_data), 32'd0);
        check({tag, "_out_src"}, 32'(bus.out_src), 32'd0);
        check({tag, "_out_last"}, 32'(bus.out_last), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
        check({tag, "_mux_sel"}, 32'(bus.mux_sel), 32'd0);
        check({tag, "_timeout_err"}, 32'(bus.timeout_err), 32'd0);
    endtask

    int rr_exp [8] = '{0, 0, 1, 1, 3, 3, 0, 0};
    int st_exp [5];

    initial begin
        clear_sources();
        bus.out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("por");
        do_reset();

        // Reset mid-burst: req 2, beat 3 of 5 on the output.
        cnt[2] = 5; nxt[2] = 8'h20; apply();
        wait_acc("rst_reach_beat3", 2, 3);
        check("rst_pre_data", 32'(bus.out_data), 32'h22);
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("midrst");
        clear_sources();
        @(posedge clk);
        #1 rst_n = 1'b1;
        cnt[3] = 1; cnt[6] = 1; apply();
        step();
        check("rst_first_grant", 32'(bus.mux_sel), 32'd3);
        check("rst_first_busy", 32'(bus.busy), 32'd1);
        drain("rst_drain");

        // Round robin among 0, 1, 3 with back-to-back 2-beat bursts.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i != 2) begin cnt[i] = 2; blen[i] = 2; reloads[i] = 3; end
        end
        apply();
        drain("rr_drain");
        check("rr_beats", 32'(log_src.size()), 32'd24);
        for (int k = 0; k < 8; k++) begin
            if (k < log_src.size()) check("rr_order", 32'(log_src[k]), 32'(rr_exp[k]));
        end

        // Back-pressure: 3 stall cycles holding beat 0x11.
        do_reset();
        cnt[1] = 4; nxt[1] = 8'h10; apply();
        wait_acc("bp_reach_beat2", 1, 2);
        bus.out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            if (s > 0) step();
            #1;
            check("bp_hold_data", 32'(bus.out_data), 32'h11);
            check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            check("bp_ready1_low", 32'(bus.req_ready[1]), 32'd0);
        end
        bus.out_ready = 1'b1;
        drain("bp_drain");
        check("bp_beats", 32'(log_data.size()), 32'd4);
        for (int k = 0; k < 4 && k < log_data.size(); k++) begin
            check("bp_data", 32'(log_data[k]), 32'(8'h10 + k));
            check("bp_last", 32'(log_last[k]), 32'(k == 3));
        end

        // Single-beat bursts from req 7 only.
        do_reset();
        cnt[7] = 1; blen[7] = 1; reloads[7] = 2; apply();
        drain("sb_drain");
        check("sb_busy_cycles", 32'(busy_cycles), 32'd3);
        check("sb_beats", 32'(log_src.size()), 32'd3);
        for (int k = 0; k < 3 && k < log_src.size(); k++) begin
            check("sb_src", 32'(log_src[k]), 32'd7);
            check("sb_last", 32'(log_last[k]), 32'd1);
        end

        // Granted requester 4 drops valid for 10 cycles while 5 waits.
        do_reset();
        cnt[4] = 3; nxt[4] = 8'h40; cnt[5] = 2; nxt[5] = 8'h50; apply();
        wait_acc("st_first_beat", 4, 1);
        hold[4] = 1; apply();
        for (int s = 0; s < 10; s++) begin
            step();
`ifndef PE_MUX_ARB_TIMEOUT_EN
            check("st_sel_held", 32'(bus.mux_sel), 32'd4);
            check("st_no_ready5", 32'(bus.req_ready[5]), 32'd0);
`endif
        end
        hold[4] = 0; apply();
        drain("st_drain");
`ifdef PE_MUX_ARB_TIMEOUT_EN
        st_exp = '{4, 5, 5, 4, 4};
        check("st_terr_pulses", 32'(terr_pulses), 32'd1);
`else
        st_exp = '{4, 4, 4, 5, 5};
        check("st_terr_pulses", 32'(terr_pulses), 32'd0);
`endif
        check("st_beats", 32'(log_src.size()), 32'd5);
        for (int k = 0; k < 5 && k < log_src.size(); k++) begin
            check("st_order", 32'(log_src[k]), 32'(st_exp[k]));
        end

        // All requesters at once from reset.
        do_reset();
        for (int i = 0; i < N; i++) cnt[i] = 2;
        apply();
        drain("all_drain");
        check("all_beats", 32'(log_src.size()), 32'd16);
        for (int k = 0; k < 16 && k < log_src.size(); k++) begin
            check("all_order", 32'(log_src[k]), 32'(k / 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
